// File: rtl/max30003_ecg_unpacker_pkg.sv
// rtl/max30003_ecg_unpacker_pkg.sv - ECG_FIFO word field map, ETAG codes and unpacker FSM states
package max30003_ecg_unpacker_pkg;

  localparam logic [2:0] ETAG_VALID     = 3'b000;
  localparam logic [2:0] ETAG_FAST      = 3'b001;
  localparam logic [2:0] ETAG_VALID_EOF = 3'b010;
  localparam logic [2:0] ETAG_FAST_EOF  = 3'b011;
  localparam logic [2:0] ETAG_EMPTY     = 3'b110;
  localparam logic [2:0] ETAG_OVF       = 3'b111;

  localparam int SAMPLE_HI = 23;
  localparam int SAMPLE_LO = 6;
  localparam int ETAG_HI   = 5;
  localparam int ETAG_LO   = 3;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_RECOVER = 2'd1,
    ST_RESYNC  = 2'd2
  } state_t;

endpackage

// File: rtl/ecg_sync_fifo.sv
// rtl/ecg_sync_fifo.sv - generic synchronous FIFO with extra-MSB pointers
module ecg_sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/max30003_ecg_unpacker.sv
// rtl/max30003_ecg_unpacker.sv - MAX30003 ECG_FIFO word decoder, sample buffer and overflow recovery
module max30003_ecg_unpacker
  import max30003_ecg_unpacker_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int OUT_W = 24,
  parameter int CNT_W = 8,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [23:0]      in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_sample,
  output logic             out_fast,
  output logic             out_eof,
  output logic [LW-1:0]    level,
  output logic             fifo_rst_req,
  input  logic             fifo_rst_ack,
  input  logic             clear_flags,
  output logic             ovf_flag,
  output logic             drop_flag,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] empty_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic [2:0]        etag;
  logic signed [17:0] raw;
  logic [OUT_W-1:0]  sext;
  logic              unused_ptag;
  logic              is_data, tag_fast, tag_eof, is_empty, is_ovf, is_err;
  logic              run, resync_hit, push, pop, drop, full, empty;
  logic [OUT_W+1:0]  head;
  state_t            state_q, state_d;

  assign etag        = in_word[ETAG_HI:ETAG_LO];
  assign raw         = in_word[SAMPLE_HI:SAMPLE_LO];
  assign sext        = OUT_W'(raw);
  assign unused_ptag = ^in_word[2:0];

  always_comb begin
    is_data  = 1'b0;
    tag_fast = 1'b0;
    tag_eof  = 1'b0;
    is_empty = 1'b0;
    is_ovf   = 1'b0;
    is_err   = 1'b0;
    case (etag)
      ETAG_VALID:     is_data = 1'b1;
      ETAG_FAST:      begin is_data = 1'b1; tag_fast = 1'b1; end
      ETAG_VALID_EOF: begin is_data = 1'b1; tag_eof = 1'b1; end
      ETAG_FAST_EOF:  begin is_data = 1'b1; tag_fast = 1'b1; tag_eof = 1'b1; end
      ETAG_EMPTY:     is_empty = 1'b1;
      ETAG_OVF:       is_ovf = 1'b1;
      default:        is_err = 1'b1;
    endcase
  end

  // After a device FIFO reset only a non-EOF sample restarts the stream.
  assign run        = in_valid && (state_q == ST_RUN);
  assign resync_hit = in_valid && (state_q == ST_RESYNC) && is_data && !tag_eof;
  assign push       = (run && is_data) || resync_hit;
  assign pop        = out_valid && out_ready;
  assign drop       = push && full && !pop;

  ecg_sync_fifo #(
    .WIDTH(OUT_W + 2),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  ({tag_fast, tag_eof, sext}),
    .dout (head),
    .full (full),
    .empty(empty),
    .level(level)
  );

  assign out_valid  = !empty;
  assign out_sample = out_valid ? head[OUT_W-1:0] : '0;
  assign out_eof    = out_valid && head[OUT_W];
  assign out_fast   = out_valid && head[OUT_W+1];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (run && is_ovf) state_d = ST_RECOVER;
      ST_RECOVER: if (fifo_rst_ack) state_d = ST_RESYNC;
      ST_RESYNC:  if (resync_hit) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_comb begin
    fifo_rst_req = 1'b0;
    if (state_q == ST_RECOVER) fifo_rst_req = 1'b1;
  end

  // Clear outranks any same-cycle set or increment.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_flags) begin
      ovf_flag  <= 1'b0;
      drop_flag <= 1'b0;
      drop_cnt  <= '0;
      empty_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (run && is_ovf) ovf_flag <= 1'b1;
      if (drop) begin
        drop_flag <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
      if (run && is_empty && empty_cnt != '1) empty_cnt <= empty_cnt + CNT_W'(1);
      if (run && is_err && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_max30003_ecg_unpacker.sv
// tb/tb_max30003_ecg_unpacker.sv - directed bench with queue-based reference model
module tb_max30003_ecg_unpacker;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_word = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_sample;
  logic        out_fast, out_eof;
  logic [4:0]  level;
  logic        fifo_rst_req;
  logic        fifo_rst_ack = 1'b0;
  logic        clear_flags = 1'b0;
  logic        ovf_flag, drop_flag;
  logic [7:0]  drop_cnt, empty_cnt, err_cnt;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  max30003_ecg_unpacker dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
    .out_fast(out_fast), .out_eof(out_eof), .level(level),
    .fifo_rst_req(fifo_rst_req), .fifo_rst_ack(fifo_rst_ack), .clear_flags(clear_flags),
    .ovf_flag(ovf_flag), .drop_flag(drop_flag), .drop_cnt(drop_cnt),
    .empty_cnt(empty_cnt), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [23:0] s;
    bit          f;
    bit          e;
  } ent_t;

  ent_t q[$];
  int   m_mode = 0;   // 0 streaming, 1 waiting for ack, 2 waiting for first plain sample
  bit   m_ovf = 0, m_drop = 0;
  int   m_drop_cnt = 0, m_empty_cnt = 0, m_err_cnt = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_mode = 0; m_ovf = 0; m_drop = 0;
      m_drop_cnt = 0; m_empty_cnt = 0; m_err_cnt = 0;
    end else begin
      int   tag, v;
      bit   was_full, take;
      ent_t ent;
      tag = int'(in_word[5:3]);
      v = int'(in_word[23:6]);
      if (v >= 131072) v = v - 262144;
      ent.s = 24'(v);
      ent.f = (tag == 1 || tag == 3);
      ent.e = (tag == 2 || tag == 3);
      was_full = (q.size() == DEPTH);
      take = 0;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid) begin
        if (m_mode == 0) begin
          if (tag <= 3) take = 1;
          else if (tag == 6) m_empty_cnt = sat(m_empty_cnt);
          else if (tag == 7) begin m_ovf = 1; m_mode = 1; end
          else m_err_cnt = sat(m_err_cnt);
        end else if (m_mode == 2 && tag <= 1) begin
          take = 1;
          m_mode = 0;
        end
      end
      if (m_mode == 1 && fifo_rst_ack) m_mode = 2;
      if (take) begin
        if (was_full && !out_ready) begin
          m_drop = 1;
          m_drop_cnt = sat(m_drop_cnt);
        end else q.push_back(ent);
      end
      if (clear_flags) begin
        m_ovf = 0; m_drop = 0;
        m_drop_cnt = 0; m_empty_cnt = 0; m_err_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("out_sample", 32'(out_sample), (q.size() != 0) ? 32'(q[0].s) : 32'd0);
      chk("out_fast", 32'(out_fast), (q.size() != 0) ? 32'(q[0].f) : 32'd0);
      chk("out_eof", 32'(out_eof), (q.size() != 0) ? 32'(q[0].e) : 32'd0);
      chk("level", 32'(level), 32'(q.size()));
      chk("fifo_rst_req", 32'(fifo_rst_req), 32'(m_mode == 1));
      chk("ovf_flag", 32'(ovf_flag), 32'(m_ovf));
      chk("drop_flag", 32'(drop_flag), 32'(m_drop));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop_cnt));
      chk("empty_cnt", 32'(empty_cnt), 32'(m_empty_cnt));
      chk("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
    end
  end

  task automatic send(input logic [23:0] w);
    in_valid = 1'b1;
    in_word = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (DEPTH + 1) @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // sample -1, ETAG 000
    send(24'hFFFFC0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_sample", 32'(out_sample), 32'hFFFFFF);
    chk("t1_fast_eof", {30'd0, out_fast, out_eof}, 32'd0);
    chk("t1_level", 32'(level), 32'd1);
    pop_one();

    for (int i = 0; i < 17; i++) send(24'((100 + i) << 6));
    chk("t2_level", 32'(level), 32'd16);
    chk("t2_drop_flag", 32'(drop_flag), 32'd1);
    chk("t2_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("t2_head", 32'(out_sample), 32'd100);
    pop_one();
    chk("t2_head2", 32'(out_sample), 32'd101);
    drain();
    chk("t2_drained", 32'(level), 32'd0);

    send(24'h000010);
    send(24'h1FFFD8);
    chk("t3_eof_sample", 32'(out_sample), 32'd0);
    chk("t3_eof_flags", {30'd0, out_fast, out_eof}, 32'd1);
    pop_one();
    chk("t3_fast_sample", 32'(out_sample), 32'h007FFF);
    chk("t3_fast_flags", {30'd0, out_fast, out_eof}, 32'd3);
    pop_one();

    repeat (3) send(24'h000030);
    send(24'h000028);
    chk("t4_empty_cnt", 32'(empty_cnt), 32'd3);
    chk("t4_err_cnt", 32'(err_cnt), 32'd1);
    chk("t4_level", 32'(level), 32'd0);
    send(24'h000020);
    chk("t4_err_cnt2", 32'(err_cnt), 32'd2);

    fifo_rst_ack = 1'b1;
    @(negedge clk);
    fifo_rst_ack = 1'b0;
    chk("t5_ack_in_run", 32'(fifo_rst_req), 32'd0);
    send(24'h000038);
    chk("t5_ovf", 32'(ovf_flag), 32'd1);
    chk("t5_req", 32'(fifo_rst_req), 32'd1);
    send(24'h000040);
    send(24'h000030);
    chk("t5_ignored_level", 32'(level), 32'd0);
    chk("t5_ignored_empty", 32'(empty_cnt), 32'd3);
    fifo_rst_ack = 1'b1;
    @(negedge clk);
    fifo_rst_ack = 1'b0;
    chk("t5_req_dropped", 32'(fifo_rst_req), 32'd0);
    send(24'h000010);
    chk("t5_eof_discarded", 32'(level), 32'd0);
    send(24'h000080);
    chk("t5_resync_push", 32'(out_sample), 32'd2);
    send(24'h000030);
    chk("t5_back_in_run", 32'(empty_cnt), 32'd4);
    pop_one();

    for (int i = 0; i < DEPTH; i++) send(24'((300 + i) << 6));
    out_ready = 1'b1;
    send(24'(400 << 6));
    out_ready = 1'b0;
    chk("t6_level_full", 32'(level), 32'd16);
    chk("t6_no_drop", 32'(drop_cnt), 32'd1);
    chk("t6_head", 32'(out_sample), 32'd301);
    clear_flags = 1'b1;
    send(24'(401 << 6));
    clear_flags = 1'b0;
    chk("t6_clear_flag", 32'(drop_flag), 32'd0);
    chk("t6_clear_cnt", 32'(drop_cnt), 32'd0);
    chk("t6_clear_ovf", 32'(ovf_flag), 32'd0);
    drain();

    repeat (260) send(24'h000030);
    chk("sat_empty_cnt", 32'(empty_cnt), 32'd255);

    send(24'h000040);
    send(24'h000048);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_level", 32'(level), 32'd0);
    chk("midreset_cnt", 32'(empty_cnt), 32'd0);
    @(negedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
